// File: rtl/store_buffer_pkg.sv
// Shared store buffer constants: default queue depth and sync FSM state encodings.
package store_buffer_pkg;
  localparam int SB_DEPTH = 4;

  typedef enum logic [1:0] {
    SYNC_IDLE  = 2'd0,
    SYNC_DRAIN = 2'd1,
    SYNC_DONE  = 2'd2
  } sync_state_t;
endpackage

// File: rtl/store_buffer_fwd_merge.sv
// Combinational per-lane merge of age-ordered store entries (index 0 oldest); newest enabled byte wins.
module sb_fwd_merge #(
  parameter int N = 4
) (
  input  logic [N-1:0]    hit,
  input  logic [N*32-1:0] data,
  input  logic [N*4-1:0]  be,
  output logic [31:0]     fwd_data,
  output logic [3:0]      fwd_mask
);
  always_comb begin
    fwd_data = '0;
    fwd_mask = '0;
    for (int i = 0; i < N; i++) begin
      if (hit[i]) begin
        for (int l = 0; l < 4; l++) begin
          if (be[i*4+l]) begin
            fwd_data[l*8 +: 8] = data[i*32+l*8 +: 8];
            fwd_mask[l]        = 1'b1;
          end
        end
      end
    end
  end
endmodule

// File: rtl/store_buffer.sv
// Circular store queue with load forwarding and a sync drain barrier.
// Head entry drives memory with zero latency; st_ready drops only when every slot is occupied.
module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int DEPTH  = SB_DEPTH,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              st_valid,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [3:0]        st_be,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  output logic [31:0]       fwd_data,
  output logic [3:0]        fwd_mask,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ack,
  input  logic              sync_req,
  output logic              sync_done,
  output logic              empty
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);

  logic [PW-1:0]     head;
  logic [PW-1:0]     tail;
  logic [PW:0]       count;
  sync_state_t       sync_state;
  logic [ADDR_W-3:0] ent_addr [DEPTH];
  logic [31:0]       ent_data [DEPTH];
  logic [3:0]        ent_be   [DEPTH];
  logic              push;
  logic              pop;
  logic [DEPTH-1:0]    age_hit;
  logic [DEPTH*32-1:0] age_data;
  logic [DEPTH*4-1:0]  age_be;
  logic              unused_addr_lsbs;

  assign unused_addr_lsbs = ^{st_addr[1:0], ld_addr[1:0]};

  assign st_ready  = (count != CNT_FULL);
  assign empty     = (count == '0);
  assign mem_we    = !empty;
  assign push      = st_valid && st_ready && (st_be != 4'b0000);
  assign pop       = mem_we && mem_ack;
  assign mem_addr  = {ent_addr[head], 2'b00};
  assign mem_wdata = ent_data[head];
  assign mem_be    = ent_be[head];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      sync_state <= SYNC_IDLE;
      sync_done  <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase

      // sync_done is registered so it is high exactly while the FSM sits in DONE
      sync_done <= 1'b0;
      case (sync_state)
        SYNC_IDLE: begin
          if (sync_req) begin
            if (empty) begin
              sync_state <= SYNC_DONE;
              sync_done  <= 1'b1;
            end else begin
              sync_state <= SYNC_DRAIN;
            end
          end
        end
        SYNC_DRAIN: begin
          if (empty) begin
            sync_state <= SYNC_DONE;
            sync_done  <= 1'b1;
          end
        end
        SYNC_DONE: sync_state <= SYNC_IDLE;
        default:   sync_state <= SYNC_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      ent_addr[tail] <= st_addr[ADDR_W-1:2];
      ent_data[tail] <= st_data;
      ent_be[tail]   <= st_be;
    end
  end

  // Present entries oldest-first; the registered count excludes a same-cycle push.
  for (genvar g = 0; g < DEPTH; g++) begin : g_age
    logic [PW-1:0] idx;
    assign idx                  = head + PW'(g);
    assign age_hit[g]           = ((PW+1)'(g) < count) && (ent_addr[idx] == ld_addr[ADDR_W-1:2]);
    assign age_data[g*32 +: 32] = ent_data[idx];
    assign age_be[g*4 +: 4]     = ent_be[idx];
  end

  sb_fwd_merge #(
    .N(DEPTH)
  ) u_fwd_merge (
    .hit      (age_hit),
    .data     (age_data),
    .be       (age_be),
    .fwd_data (fwd_data),
    .fwd_mask (fwd_mask)
  );
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: memory writes checked by a scoreboard monitor, other outputs checked inline.
module tb_store_buffer;
  logic        clk = 1'b0;
  logic        reset;
  logic        st_valid;
  logic [31:0] st_addr;
  logic [31:0] st_data;
  logic [3:0]  st_be;
  logic        st_ready;
  logic [31:0] ld_addr;
  logic [31:0] fwd_data;
  logic [3:0]  fwd_mask;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic        sync_req;
  logic        sync_done;
  logic        empty;

  int          checks = 0;
  int          errors = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_exp;

  always #5 clk = ~clk;

  store_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .st_valid  (st_valid),
    .st_addr   (st_addr),
    .st_data   (st_data),
    .st_be     (st_be),
    .st_ready  (st_ready),
    .ld_addr   (ld_addr),
    .fwd_data  (fwd_data),
    .fwd_mask  (fwd_mask),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_ack   (mem_ack),
    .sync_req  (sync_req),
    .sync_done (sync_done),
    .empty     (empty)
  );

  task automatic check(input string name, input logic [67:0] act, input logic [67:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // One clock of stimulus; enq records the store the model expects to be enqueued.
  task automatic step(input bit v, input logic [31:0] a, input logic [31:0] d,
                      input logic [3:0] be, input bit ack, input bit enq);
    st_valid = v;
    st_addr  = a;
    st_data  = d;
    st_be    = be;
    mem_ack  = ack;
    if (enq) exp_q.push_back({a[31:2], 2'b00, d, be});
    @(posedge clk);
    #1;
    st_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    int n = 0;
    mem_ack = 1'b1;
    while (!empty && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_empty"}, empty, 1'b1);
    check({name, "_sb_left"}, exp_q.size(), 0);
    mem_ack = 1'b0;
  endtask

  // Every accepted memory write must match the oldest outstanding expected store.
  always @(negedge clk) begin
    if (!reset && mem_we && mem_ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_write_unexpected: got addr %0h data %0h be %0h expected no write",
                 mem_addr, mem_wdata, mem_be);
      end else begin
        mon_exp = exp_q.pop_front();
        check("mem_write", {mem_addr, mem_wdata, mem_be}, mon_exp);
      end
    end
  end

  initial begin
    reset    = 1'b1;
    st_valid = 1'b0;
    st_addr  = '0;
    st_data  = '0;
    st_be    = '0;
    ld_addr  = '0;
    mem_ack  = 1'b0;
    sync_req = 1'b0;

    @(negedge clk);
    check("rst_st_ready", st_ready, 1'b1);
    check("rst_empty", empty, 1'b1);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_sync_done", sync_done, 1'b0);
    check("rst_fwd_mask", fwd_mask, 4'h0);
    check("rst_fwd_data", fwd_data, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Fill without drain, then a refused fifth store
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 32'(i * 4), 32'hFEFEFEFE, 4'hF, 1'b0, 1'b1);
      @(negedge clk);
      check($sformatf("fill_st_ready_%0d", i), st_ready, (i < 3) ? 1'b1 : 1'b0);
    end
    step(1'b1, 32'h10, 32'hFEFEFEFE, 4'hF, 1'b0, 1'b0);
    @(negedge clk);
    check("fill_refused_st_ready", st_ready, 1'b0);
    check("fill_mem_we", mem_we, 1'b1);
    check("fill_mem_addr", mem_addr, 32'h0);
    check("fill_mem_wdata", mem_wdata, 32'hFEFEFEFE);
    drain("fill");

    // Sixteen stores streamed with mem_ack held high
    for (int i = 0; i < 16; i++)
      step(1'b1, 32'(i * 4), 32'hFEFEFEFE, 4'hF, 1'b1, 1'b1);
    @(negedge clk);
    check("drain16_not_yet_empty", empty, 1'b0);
    check("drain16_last_we", mem_we, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("drain16_empty", empty, 1'b1);
    check("drain16_sb_left", exp_q.size(), 0);
    mem_ack = 1'b0;

    // Forwarding merge, same-cycle push exclusion, zero-byte-enable store
    step(1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b0, 1'b1);
    step(1'b1, 32'h21, 32'hAABBCCDD, 4'b0010, 1'b0, 1'b1);
    ld_addr = 32'h20;
    @(negedge clk);
    check("fwd_merge_mask", fwd_mask, 4'b1111);
    check("fwd_merge_data", fwd_data, 32'h1122CC44);
    ld_addr = 32'h23;
    @(negedge clk);
    check("fwd_lsb_ignored_data", fwd_data, 32'h1122CC44);
    ld_addr  = 32'h24;
    st_valid = 1'b1;
    st_addr  = 32'h24;
    st_data  = 32'h55667788;
    st_be    = 4'hF;
    #2;
    check("fwd_pushing_excluded", fwd_mask, 4'h0);
    exp_q.push_back({30'(32'h24 >> 2), 2'b00, 32'h55667788, 4'hF});
    @(posedge clk);
    #1;
    st_valid = 1'b0;
    @(negedge clk);
    check("fwd_after_push_mask", fwd_mask, 4'hF);
    check("fwd_after_push_data", fwd_data, 32'h55667788);
    step(1'b1, 32'h28, 32'hDEADBEEF, 4'h0, 1'b0, 1'b0);
    ld_addr = 32'h28;
    @(negedge clk);
    check("fwd_be0_not_queued", fwd_mask, 4'h0);
    check("fwd_miss_data", fwd_data, 32'h0);
    drain("fwd");

    // Full buffer with simultaneous push and pop, then at count 3
    for (int i = 0; i < 4; i++)
      step(1'b1, 32'hA0 + 32'(i * 4), 32'h1000 + 32'(i), 4'hF, 1'b0, 1'b1);
    step(1'b1, 32'hB0, 32'h2000, 4'hF, 1'b1, 1'b0);
    mem_ack = 1'b0;
    @(negedge clk);
    check("full_pp_st_ready", st_ready, 1'b1);
    check("full_pp_head", mem_addr, 32'hA4);
    step(1'b1, 32'hB4, 32'h2004, 4'hF, 1'b1, 1'b1);
    mem_ack = 1'b0;
    @(negedge clk);
    check("cnt3_pp_st_ready", st_ready, 1'b1);
    check("cnt3_pp_head", mem_addr, 32'hA8);
    step(1'b1, 32'hB8, 32'h2008, 4'hF, 1'b0, 1'b1);
    @(negedge clk);
    check("cnt3_refill_full", st_ready, 1'b0);
    drain("full");

    // Sync with two pending entries, one ack per cycle
    step(1'b1, 32'hC0, 32'h3000, 4'hF, 1'b0, 1'b1);
    step(1'b1, 32'hC4, 32'h3004, 4'hF, 1'b0, 1'b1);
    sync_req = 1'b1;
    step(1'b0, 32'h0, 32'h0, 4'h0, 1'b1, 1'b0);
    sync_req = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("sync_done_c%0d", c), sync_done, (c == 2) ? 1'b1 : 1'b0);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;
    check("sync_sb_left", exp_q.size(), 0);
    sync_req = 1'b1;
    @(posedge clk);
    #1;
    sync_req = 1'b0;
    @(negedge clk);
    check("sync_empty_done", sync_done, 1'b1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("sync_empty_done_drop", sync_done, 1'b0);

    // Asynchronous reset while three entries are pending
    for (int i = 0; i < 3; i++)
      step(1'b1, 32'hD0 + 32'(i * 4), 32'h4000 + 32'(i), 4'hF, 1'b0, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_mid_mem_we", mem_we, 1'b0);
    check("rst_mid_empty", empty, 1'b1);
    check("rst_mid_st_ready", st_ready, 1'b1);
    exp_q.delete();
    mem_ack = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check($sformatf("rst_after_mem_we_%0d", c), mem_we, 1'b0);
      @(posedge clk);
      #1;
    end
    mem_ack = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
